// File: rtl/regwrite_arbiter_if.sv
// Bundle of signals between the write-port controller, the ALU/load producers,
// the issue-stage hazard queries and the register file write port.
interface regwrite_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  q1_reg;
    logic [4:0]  q2_reg;
    logic [4:0]  q3_reg;
    logic        q1_busy;
    logic        q2_busy;
    logic        q3_busy;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [63:0] Write_d;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data, ld_issue, ld_issue_rd,
        output q1_reg, q2_reg, q3_reg,
        input  alu_ready, ld_ready, q1_busy, q2_busy, q3_busy,
        input  RegWrite, Write_register, Write_d
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data, ld_issue, ld_issue_rd,
        input  q1_reg, q2_reg, q3_reg,
        output alu_ready, ld_ready, q1_busy, q2_busy, q3_busy,
        output RegWrite, Write_register, Write_d
    );
endinterface

// File: rtl/regwrite_arbiter.sv
// Shares the register file write port between ALU writeback (via a skid FIFO)
// and load returns, and tracks outstanding load destinations for hazard stalls.
module regwrite_arbiter #(
    parameter int ALU_FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    regwrite_arbiter_if.slave bus
);
    localparam int         PTR_W = $clog2(ALU_FIFO_DEPTH);
    localparam logic [4:0] XZR   = 5'd31;

    logic [4:0]                fifo_rd_q   [ALU_FIFO_DEPTH];
    logic [63:0]               fifo_data_q [ALU_FIFO_DEPTH];
    logic [ALU_FIFO_DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                      last_ld_q, last_ld_d;
    logic                      rw_q, rw_d;
    logic [4:0]                wreg_q, wreg_d;
    logic [63:0]               wd_q, wd_d;
    logic [30:0]               sb_q, sb_d;

    logic fifo_full, fifo_empty, alu_push, ld_win, alu_win;
    logic [4:0]  win_rd;
    logic [63:0] win_data;

    // Per-slot valid bits make full/empty and the busy search trivial.
    assign fifo_full  = fifo_vld_q[wr_ptr_q];
    assign fifo_empty = !fifo_vld_q[rd_ptr_q];
    assign alu_push   = bus.alu_valid && bus.alu_ready;

    // Last-winner flag only flips when both sides actually contend.
    assign ld_win  = !rst && bus.ld_valid && (fifo_empty || !last_ld_q);
    assign alu_win = !rst && !fifo_empty && !ld_win;

    assign bus.alu_ready      = !fifo_full && !rst;
    assign bus.ld_ready       = ld_win;
    assign bus.RegWrite       = rw_q;
    assign bus.Write_register = wreg_q;
    assign bus.Write_d        = wd_q;

    function automatic logic is_busy(input logic [4:0] q);
        logic hit;
        hit = 1'b0;
        if (q != XZR) begin
            if (sb_q[q]) hit = 1'b1;
            for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
                if (fifo_vld_q[i] && (fifo_rd_q[i] == q)) hit = 1'b1;
            end
            if (rw_q && (wreg_q == q)) hit = 1'b1;
        end
        return hit && !rst;
    endfunction

    always_comb begin
        bus.q1_busy = is_busy(bus.q1_reg);
        bus.q2_busy = is_busy(bus.q2_reg);
        bus.q3_busy = is_busy(bus.q3_reg);
    end

    always_comb begin
        win_rd   = bus.ld_rd;
        win_data = bus.ld_data;
        if (alu_win) begin
            win_rd   = fifo_rd_q[rd_ptr_q];
            win_data = fifo_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        fifo_vld_d = fifo_vld_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (alu_win) begin
            fifo_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = rd_ptr_q + PTR_W'(1);
        end
        if (alu_push) begin
            fifo_vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        last_ld_d = last_ld_q;
        if (bus.ld_valid && !fifo_empty) last_ld_d = ld_win;
        rw_d   = 1'b0;
        wreg_d = wreg_q;
        wd_d   = wd_q;
        if (ld_win || alu_win) begin
            rw_d   = (win_rd != XZR);
            wreg_d = win_rd;
            wd_d   = win_data;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    always_comb begin
        sb_d = sb_q;
        if (ld_win && (bus.ld_rd != XZR)) sb_d = sb_d & ~(31'(1) << bus.ld_rd);
        if (bus.ld_issue && (bus.ld_issue_rd != XZR)) sb_d = sb_d | (31'(1) << bus.ld_issue_rd);
    end

    always_ff @(posedge clk) begin
        if (alu_push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.alu_rd;
            fifo_data_q[wr_ptr_q] <= bus.alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_ld_q  <= 1'b0;
            rw_q       <= 1'b0;
            wreg_q     <= '0;
            wd_q       <= '0;
            sb_q       <= '0;
        end else begin
            fifo_vld_q <= fifo_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_ld_q  <= last_ld_d;
            rw_q       <= rw_d;
            wreg_q     <= wreg_d;
            wd_q       <= wd_d;
            sb_q       <= sb_d;
        end
    end
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_regwrite_arbiter;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    regwrite_arbiter_if bus ();

    regwrite_arbiter #(.ALU_FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending ALU writes as an ordered queue, pending loads as a set.
    typedef struct packed { logic [4:0] rd; logic [63:0] d; } ent_t;
    ent_t        m_q[$];
    bit   [31:0] m_sb;
    bit          m_last_ld;
    bit          m_rw;
    logic [4:0]  m_wr;
    logic [63:0] m_wd;

    function automatic bit m_ld_wins();
        return !rst && bus.ld_valid && (m_q.size() == 0 || !m_last_ld);
    endfunction

    function automatic bit m_busy(input logic [4:0] q);
        if (rst || q == 5'd31) return 1'b0;
        if (m_sb[q]) return 1'b1;
        foreach (m_q[i]) if (m_q[i].rd == q) return 1'b1;
        if (m_rw && m_wr == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit   ldw, aluw, push;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_sb = '0; m_last_ld = 1'b0; m_rw = 1'b0; m_wr = '0; m_wd = '0;
            return;
        end
        ldw  = m_ld_wins();
        aluw = !ldw && m_q.size() > 0;
        push = bus.alu_valid && m_q.size() < DEPTH;
        if (bus.ld_valid && m_q.size() > 0) m_last_ld = ldw;
        if (ldw) begin
            m_rw = (bus.ld_rd != 5'd31); m_wr = bus.ld_rd; m_wd = bus.ld_data;
            if (bus.ld_rd != 5'd31) m_sb[bus.ld_rd] = 1'b0;
        end else if (aluw) begin
            e = m_q.pop_front();
            m_rw = (e.rd != 5'd31); m_wr = e.rd; m_wd = e.d;
        end else begin
            m_rw = 1'b0;
        end
        if (push) m_q.push_back('{rd: bus.alu_rd, d: bus.alu_data});
        if (bus.ld_issue && bus.ld_issue_rd != 5'd31) m_sb[bus.ld_issue_rd] = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("alu_ready", bus.alu_ready, !rst && m_q.size() < DEPTH);
            chk("ld_ready", bus.ld_ready, m_ld_wins());
            chk("RegWrite", bus.RegWrite, m_rw);
            chk("Write_register", bus.Write_register, m_wr);
            chk("Write_d", bus.Write_d, m_wd);
            chk("q1_busy", bus.q1_busy, m_busy(bus.q1_reg));
            chk("q2_busy", bus.q2_busy, m_busy(bus.q2_reg));
            chk("q3_busy", bus.q3_busy, m_busy(bus.q3_reg));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
        bus.ld_issue = 1'b0; bus.ld_issue_rd = '0;
    endtask

    logic [63:0] alu_seen[$];
    int ai, li, cyc;

    initial begin
        rst = 1'b1;
        idle();
        bus.q1_reg = 5'd31; bus.q2_reg = 5'd31; bus.q3_reg = 5'd31;
        repeat (2) tick();
        chk_en = 1'b1;

        // Reset with traffic offered
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'hdead;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd3;
        bus.q1_reg = 5'd3; bus.q2_reg = 5'd4;
        @(negedge clk);
        chk("rst_RegWrite", bus.RegWrite, 1'b0);
        chk("rst_alu_ready", bus.alu_ready, 1'b0);
        chk("rst_ld_ready", bus.ld_ready, 1'b0);
        chk("rst_q1_busy", bus.q1_busy, 1'b0);
        tick();
        rst = 1'b0; idle();
        @(negedge clk);
        chk("rel_alu_ready", bus.alu_ready, 1'b1);
        chk("rel_RegWrite", bus.RegWrite, 1'b0);
        chk("rel_q1_busy", bus.q1_busy, 1'b0);
        tick();

        // ALU-only write of X3
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h1111;
        @(negedge clk);
        chk("alu_c0_q1_busy", bus.q1_busy, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("alu_c1_q1_busy", bus.q1_busy, 1'b1);
        chk("alu_c1_RegWrite", bus.RegWrite, 1'b0);
        tick();
        @(negedge clk);
        chk("alu_c2_RegWrite", bus.RegWrite, 1'b1);
        chk("alu_c2_Write_register", bus.Write_register, 64'd3);
        chk("alu_c2_Write_d", bus.Write_d, 64'h1111);
        chk("alu_c2_q1_busy", bus.q1_busy, 1'b1);
        tick();
        @(negedge clk);
        chk("alu_c3_q1_busy", bus.q1_busy, 1'b0);
        chk("alu_c3_RegWrite", bus.RegWrite, 1'b0);
        tick();

        // Load contention: X1, X2 queued against load X5
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 64'ha1;
        tick();
        bus.alu_rd = 5'd2; bus.alu_data = 64'ha2;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd5; bus.ld_data = 64'h55;
        @(negedge clk);
        chk("cont_c1_ld_ready", bus.ld_ready, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("cont_c2_Write_register", bus.Write_register, 64'd5);
        chk("cont_c2_Write_d", bus.Write_d, 64'h55);
        tick();
        @(negedge clk);
        chk("cont_c3_Write_register", bus.Write_register, 64'd1);
        chk("cont_c3_Write_d", bus.Write_d, 64'ha1);
        tick();
        @(negedge clk);
        chk("cont_c4_Write_register", bus.Write_register, 64'd2);
        chk("cont_c4_RegWrite", bus.RegWrite, 1'b1);
        tick();

        // Scoreboard: issue X7, 5 idle cycles, return X7
        bus.q3_reg = 5'd7;
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7;
        @(negedge clk);
        chk("sb_issue_q3_busy", bus.q3_busy, 1'b0);
        tick();
        idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("sb_wait_q3_busy", bus.q3_busy, 1'b1);
            tick();
        end
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 64'h77;
        @(negedge clk);
        chk("sb_ret_ld_ready", bus.ld_ready, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("sb_wr_Write_register", bus.Write_register, 64'd7);
        chk("sb_wr_q3_busy", bus.q3_busy, 1'b1);
        tick();
        @(negedge clk);
        chk("sb_done_q3_busy", bus.q3_busy, 1'b0);
        tick();
        // Same-cycle issue and return of X7 leaves it pending
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 64'h78;
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("sb_same_q3_busy", bus.q3_busy, 1'b1);
        tick();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 64'h79;
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("sb_clear_q3_busy", bus.q3_busy, 1'b0);
        tick();

        // XZR: ALU write to X31 and a load issue to X31
        bus.q1_reg = 5'd31;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd31; bus.alu_data = 64'h3131;
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd31;
        tick();
        idle();
        @(negedge clk);
        chk("xzr_c1_q1_busy", bus.q1_busy, 1'b0);
        tick();
        @(negedge clk);
        chk("xzr_c2_RegWrite", bus.RegWrite, 1'b0);
        chk("xzr_c2_Write_register", bus.Write_register, 64'd31);
        chk("xzr_c2_Write_d", bus.Write_d, 64'h3131);
        chk("xzr_c2_q1_busy", bus.q1_busy, 1'b0);
        tick();

        // Reset mid-operation discards queued ALU entry and pending load
        bus.q1_reg = 5'd4; bus.q2_reg = 5'd8;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 64'h44;
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd8;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_RegWrite", bus.RegWrite, 1'b0);
        chk("midrst_q1_busy", bus.q1_busy, 1'b0);
        chk("midrst_q2_busy", bus.q2_busy, 1'b0);
        tick();

        // Backpressure: continuous loads, three ALU pushes
        ai = 0; li = 0; cyc = 0;
        while (alu_seen.size() < 3 && cyc < 40) begin
            bus.ld_valid = 1'b1; bus.ld_rd = 5'(10 + (li % 8)); bus.ld_data = 64'hb000 + 64'(li);
            bus.alu_valid = (ai < 3); bus.alu_rd = 5'(20 + ai); bus.alu_data = 64'ha000 + 64'(ai);
            @(negedge clk);
            if (cyc == 2) begin
                chk("bp_c2_alu_ready", bus.alu_ready, 1'b0);
                chk("bp_c2_accepted", 64'(ai), 64'd2);
            end
            if (bus.alu_valid && bus.alu_ready) ai++;
            if (bus.ld_ready) li++;
            if (bus.RegWrite && bus.Write_d[63:12] == 52'ha) alu_seen.push_back(bus.Write_d);
            tick();
            cyc++;
        end
        chk("bp_alu_writes", 64'(alu_seen.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < alu_seen.size()) chk("bp_order", alu_seen[k], 64'ha000 + 64'(k));
        end
        idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
